type_rule_cfg_loader: RTL and testbench
=======================================

// Module: type_rule_cfg_loader
// PURPOSE
//  Configuration-side writer for the parser's type-lookup rule tables. Accepts a
//  32-bit word stream (valid/ready, last-delimited) from the control path, assembles
//  one packed type_rule_t, and commits it with a one-cycle write-enable pulse to a
//  selected rule slot of a selected lookup stage. Also supports clearing all rules
//  of a stage. Sits between the config bus and every stage's rule write port.
// PARAMETERS
//  STAGE_NUM   4    number of lookup stages driven (stage id 0..STAGE_NUM-1)
//  RULE_NUM    8    rule slots per stage (rule index 0..RULE_NUM-1)
//  RULE_W      $bits(type_rule_t)  packed rule width
//  CFG_W       32   config word width (fixed 32)
//  localparam PAYLOAD_WORDS = (RULE_W+CFG_W-1)/CFG_W
// PORTS
//  i_clk           in   1                   clock
//  i_rst           in   1                   async reset, active-high
//  i_cfg_valid     in   1                   config word valid
//  o_cfg_ready     out  1                   loader accepts word (xfer = valid & ready)
//  i_cfg_data      in   32                  config word
//  i_cfg_last      in   1                   last word of command
//  o_rule_wren     out  STAGE_NUM*RULE_NUM  write enables; bit = stage*RULE_NUM+rule
//  o_type_rule     out  RULE_W              packed rule to write (type_rule_t layout)
//  o_err           out  1                   one-cycle pulse on malformed command
//  o_wr_cnt        out  16                  committed writes (saturating)
//  o_err_cnt       out  16                  malformed commands (saturating)
// BEHAVIOUR
//  Reset: state S_HDR, o_rule_wren=0, o_type_rule=0, o_err=0, counters=0,
//   o_cfg_ready=0 while i_rst high. Reset mid-command aborts it; no wren issued.
//  Header word: [31:24] opcode, [23:16] stage id, [15:8] rule index, [7:0] ignored.
//   0x01 WRITE: followed by exactly PAYLOAD_WORDS words; last only on final word.
//   0x02 CLEAR: header alone, i_cfg_last=1 on header; stage id checked, rule idx ignored.
//  Payload word k (0-based) loads shadow bits [k*32 +: 32]; bits >= RULE_W dropped.
//  States:
//   S_HDR: ready=1. On xfer decode header.
//     WRITE, stage<STAGE_NUM, idx<RULE_NUM, !last -> clear shadow, wcnt=0, S_PAYLOAD.
//     CLEAR, stage valid, last -> S_COMMIT (clear).
//     Bad opcode/stage/idx, or last mismatch: if last -> err, stay S_HDR;
//       else -> err, S_DRAIN.
//   S_PAYLOAD: ready=1. On xfer store word, wcnt++.
//     wcnt==PAYLOAD_WORDS-1 & last -> S_COMMIT.
//     wcnt<PAYLOAD_WORDS-1 & last -> err, S_HDR (short command, no write).
//     wcnt==PAYLOAD_WORDS-1 & !last -> err, S_DRAIN (long command, no write).
//   S_COMMIT: ready=0, exactly one cycle. WRITE: o_type_rule<=shadow, one wren bit.
//     CLEAR: o_type_rule<=0, all RULE_NUM bits of that stage. wr_cnt++ ; -> S_HDR.
//   S_DRAIN: ready=1, discard words until xfer with last -> S_HDR.
//  Outputs registered. o_rule_wren high for the single cycle after S_COMMIT is
//   entered (2 cycles after final-word xfer); o_type_rule valid that cycle and held
//   until next commit. Min spacing between commits: PAYLOAD_WORDS+2 cycles.
//  o_err pulses one cycle, the cycle after the offending xfer; err_cnt++ same edge.
//  Counters saturate at 16'hFFFF; never wrap.
//  i_cfg_valid low in any state: state holds, no side effects (bubbles allowed).
// TESTING
//  (STAGE_NUM=4, RULE_NUM=8, RULE_W=70 -> PAYLOAD_WORDS=3)
//  T1 WRITE hdr 0x01_02_05_00, words 0x11111111,0x22222222,0x3F(last) -> one-cycle
//     wren bit 21, o_type_rule=70'h3F_22222222_11111111, wr_cnt=1, no err.
//  T2 CLEAR hdr 0x02_01_00_00 with last -> wren bits 15:8 all high 1 cycle, rule=0.
//  T3 WRITE with last on 2nd payload word -> o_err pulse, err_cnt=1, no wren;
//     next valid WRITE commits normally.
//  T4 WRITE 4 payload words (last on 4th) -> err after 3rd word, 4th drained, no wren.
//  T5 bad opcode 0x07 / stage 4 / idx 8 without last -> err, drain to last, no wren.
//  T6 assert i_rst after 2nd payload word -> no wren, outputs 0; random valid gaps
//     during T1 give identical result; counters saturate at 0xFFFF under forcing.

Source files
------------

// File: rtl/type_rule_cfg_loader.sv
// Assembles a packed lookup rule from a last-delimited 32-bit config stream and
// commits it (or clears a whole stage) through one-hot rule write enables.
module type_rule_cfg_loader #(
    parameter int unsigned STAGE_NUM = 4,
    parameter int unsigned RULE_NUM  = 8,
    parameter int unsigned RULE_W    = 70
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_cfg_valid,
    output logic                          o_cfg_ready,
    input  logic [31:0]                   i_cfg_data,
    input  logic                          i_cfg_last,
    output logic [STAGE_NUM*RULE_NUM-1:0] o_rule_wren,
    output logic [RULE_W-1:0]             o_type_rule,
    output logic                          o_err,
    output logic [15:0]                   o_wr_cnt,
    output logic [15:0]                   o_err_cnt
);

    localparam int unsigned CFG_W         = 32;
    localparam int unsigned PAYLOAD_WORDS = (RULE_W + CFG_W - 1) / CFG_W;
    localparam int unsigned WCNT_W        = $clog2(PAYLOAD_WORDS + 1);
    localparam int unsigned WREN_W        = STAGE_NUM * RULE_NUM;
    localparam int unsigned CNT_W         = 16;
    localparam int unsigned CW_IDX_W      = $clog2(CFG_W);
    localparam int unsigned RW_IDX_W      = $clog2(RULE_W);
    localparam logic [7:0]  OP_WRITE      = 8'h01;
    localparam logic [7:0]  OP_CLEAR      = 8'h02;

    typedef enum logic [1:0] {
        S_HDR     = 2'd0,
        S_PAYLOAD = 2'd1,
        S_COMMIT  = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [RULE_W-1:0]   shadow_q, shadow_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [7:0]          stage_q, stage_d;
    logic [7:0]          ridx_q, ridx_d;
    logic                clr_q, clr_d;
    logic [WREN_W-1:0]   wren_q, wren_d;
    logic [RULE_W-1:0]   rule_q, rule_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic                ready_q, ready_d;

    logic                xfer;
    logic [7:0]          hdr_op, hdr_stage, hdr_rule;
    logic                stage_ok, rule_ok, last_payload;

    assign xfer         = i_cfg_valid & ready_q;
    assign hdr_op       = i_cfg_data[31:24];
    assign hdr_stage    = i_cfg_data[23:16];
    assign hdr_rule     = i_cfg_data[15:8];
    assign stage_ok     = 32'(hdr_stage) < STAGE_NUM;
    assign rule_ok      = 32'(hdr_rule) < RULE_NUM;
    assign last_payload = (wcnt_q == WCNT_W'(PAYLOAD_WORDS - 1));

    // Next-state, shadow assembly and registered-output computation
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        wcnt_d    = wcnt_q;
        stage_d   = stage_q;
        ridx_d    = ridx_q;
        clr_d     = clr_q;
        wren_d    = '0;
        rule_d    = rule_q;
        err_d     = 1'b0;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            S_HDR: begin
                if (xfer) begin
                    if (hdr_op == OP_WRITE && stage_ok && rule_ok && !i_cfg_last) begin
                        shadow_d = '0;
                        wcnt_d   = '0;
                        stage_d  = hdr_stage;
                        ridx_d   = hdr_rule;
                        clr_d    = 1'b0;
                        state_d  = S_PAYLOAD;
                    end else if (hdr_op == OP_CLEAR && stage_ok && i_cfg_last) begin
                        stage_d = hdr_stage;
                        clr_d   = 1'b1;
                        state_d = S_COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = i_cfg_last ? S_HDR : S_DRAIN;
                    end
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    // Bits at or above RULE_W in the final word are simply not stored
                    for (int unsigned b = 0; b < RULE_W; b++) begin
                        if (b / CFG_W == 32'(wcnt_q))
                            shadow_d[RW_IDX_W'(b)] = i_cfg_data[CW_IDX_W'(b % CFG_W)];
                    end
                    wcnt_d = wcnt_q + WCNT_W'(1);
                    if (last_payload) begin
                        if (i_cfg_last) begin
                            state_d = S_COMMIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end else if (i_cfg_last) begin
                        err_d   = 1'b1;
                        state_d = S_HDR;
                    end
                end
            end
            S_COMMIT: begin
                if (clr_q) begin
                    rule_d = '0;
                    wren_d = WREN_W'({RULE_NUM{1'b1}}) << (32'(stage_q) * RULE_NUM);
                end else begin
                    rule_d = shadow_q;
                    wren_d = WREN_W'(1) << (32'(stage_q) * RULE_NUM + 32'(ridx_q));
                end
                wr_cnt_d = (wr_cnt_q == '1) ? wr_cnt_q : wr_cnt_q + CNT_W'(1);
                state_d  = S_HDR;
            end
            S_DRAIN: begin
                if (xfer && i_cfg_last)
                    state_d = S_HDR;
            end
            default: state_d = S_HDR;
        endcase

        if (err_d)
            err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_W'(1);
    end

    assign ready_d = (state_d != S_COMMIT);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_HDR;
            shadow_q  <= '0;
            wcnt_q    <= '0;
            stage_q   <= '0;
            ridx_q    <= '0;
            clr_q     <= 1'b0;
            wren_q    <= '0;
            rule_q    <= '0;
            err_q     <= 1'b0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            wcnt_q    <= wcnt_d;
            stage_q   <= stage_d;
            ridx_q    <= ridx_d;
            clr_q     <= clr_d;
            wren_q    <= wren_d;
            rule_q    <= rule_d;
            err_q     <= err_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
            ready_q   <= ready_d;
        end
    end

    assign o_cfg_ready = ready_q;
    assign o_rule_wren = wren_q;
    assign o_type_rule = rule_q;
    assign o_err       = err_q;
    assign o_wr_cnt    = wr_cnt_q;
    assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_type_rule_cfg_loader.sv
// Directed plus randomized command stream against a command-level model of the
// rule loader: each command resolves to one write, one clear or one error.
module tb_type_rule_cfg_loader;

    localparam int unsigned STAGE_NUM = 4;
    localparam int unsigned RULE_NUM  = 8;
    localparam int unsigned RULE_W    = 70;
    localparam int unsigned PW        = 3;
    localparam int unsigned WREN_W    = STAGE_NUM * RULE_NUM;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic                 i_cfg_valid;
    logic                 o_cfg_ready;
    logic [31:0]          i_cfg_data;
    logic                 i_cfg_last;
    logic [WREN_W-1:0]    o_rule_wren;
    logic [RULE_W-1:0]    o_type_rule;
    logic                 o_err;
    logic [15:0]          o_wr_cnt;
    logic [15:0]          o_err_cnt;

    type_rule_cfg_loader #(
        .STAGE_NUM(STAGE_NUM), .RULE_NUM(RULE_NUM), .RULE_W(RULE_W)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
        .i_cfg_data(i_cfg_data), .i_cfg_last(i_cfg_last), .o_rule_wren(o_rule_wren),
        .o_type_rule(o_type_rule), .o_err(o_err), .o_wr_cnt(o_wr_cnt), .o_err_cnt(o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Output events observed on the falling edge
    logic [WREN_W-1:0] ev_wren_q[$];
    logic [RULE_W-1:0] ev_rule_q[$];
    int unsigned       ev_cyc_q[$];
    int unsigned       err_cyc_q[$];

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_rule_wren != '0) begin
                ev_wren_q.push_back(o_rule_wren);
                ev_rule_q.push_back(o_type_rule);
                ev_cyc_q.push_back(cyc);
            end
            if (o_err) err_cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Command under construction
    logic [31:0] cw[16];
    logic        cl[16];
    int          cn;

    // Model state
    logic [15:0]       m_wr_cnt, m_err_cnt;
    logic [RULE_W-1:0] m_rule;
    int                exp_kind;   // 1 commit, 2 error
    logic [WREN_W-1:0] exp_wren;
    logic [RULE_W-1:0] exp_rule;
    int                exp_trig;

    function automatic logic [15:0] sat(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    function automatic logic [31:0] hdr(input int op, input int st, input int ix);
        return {8'(op), 8'(st), 8'(ix), 8'($urandom)};
    endfunction

    task automatic cmd_start();
        cn = 0;
    endtask

    task automatic add(input logic [31:0] w, input logic last);
        cw[cn] = w;
        cl[cn] = last;
        cn++;
    endtask

    // Resolve a whole command from its words: payload count decides the outcome
    task automatic model();
        int op, st, ix, n;
        logic [95:0] full;
        op = int'(cw[0][31:24]);
        st = int'(cw[0][23:16]);
        ix = int'(cw[0][15:8]);
        exp_wren = '0;
        exp_rule = '0;
        if (op == 1 && st < STAGE_NUM && ix < RULE_NUM && !cl[0]) begin
            n = 0;
            for (int j = 1; j < cn; j++) if (cl[j] && n == 0) n = j;
            if (n == PW) begin
                exp_kind = 1;
                exp_trig = PW;
                full = {cw[3], cw[2], cw[1]};
                exp_rule = full[RULE_W-1:0];
                exp_wren[st*RULE_NUM+ix] = 1'b1;
            end else begin
                exp_kind = 2;
                exp_trig = (n < PW) ? n : PW;
            end
        end else if (op == 2 && st < STAGE_NUM && cl[0]) begin
            exp_kind = 1;
            exp_trig = 0;
            for (int r = 0; r < RULE_NUM; r++) exp_wren[st*RULE_NUM+r] = 1'b1;
        end else begin
            exp_kind = 2;
            exp_trig = 0;
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Drive the command word by word, optionally with valid bubbles
    task automatic drive(input bit gaps, output int unsigned trig_cyc);
        bit rdy;
        trig_cyc = 0;
        for (int k = 0; k < cn; k++) begin
            if (gaps) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    i_cfg_valid = 1'b0;
                    i_cfg_data  = $urandom;
                    i_cfg_last  = 1'($urandom);
                    tick();
                end
            end
            i_cfg_valid = 1'b1;
            i_cfg_data  = cw[k];
            i_cfg_last  = cl[k];
            for (int t = 0; t <= 20; t++) begin
                @(negedge i_clk);
                rdy = o_cfg_ready;
                tick();
                if (rdy) break;
                if (t == 20) begin
                    failures++;
                    $error("FAIL ready_timeout observed=0 expected=1");
                end
            end
            if (k == exp_trig) trig_cyc = cyc;
        end
        i_cfg_valid = 1'b0;
        i_cfg_last  = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input bit gaps);
        int unsigned tc;
        model();
        ev_wren_q.delete(); ev_rule_q.delete(); ev_cyc_q.delete(); err_cyc_q.delete();
        drive(gaps, tc);
        repeat (5) tick();
        if (exp_kind == 1) begin
            m_wr_cnt = sat(m_wr_cnt);
            m_rule   = exp_rule;
            chk({tag, "_wren_events"}, 128'(ev_wren_q.size()), 128'(1));
            if (ev_wren_q.size() == 1) begin
                chk({tag, "_wren"}, 128'(ev_wren_q[0]), 128'(exp_wren));
                chk({tag, "_rule"}, 128'(ev_rule_q[0]), 128'(exp_rule));
                chk({tag, "_wren_latency"}, 128'(ev_cyc_q[0]), 128'(tc + 1));
            end
            chk({tag, "_err_events"}, 128'(err_cyc_q.size()), 128'(0));
        end else begin
            m_err_cnt = sat(m_err_cnt);
            chk({tag, "_wren_events"}, 128'(ev_wren_q.size()), 128'(0));
            chk({tag, "_err_events"}, 128'(err_cyc_q.size()), 128'(1));
            if (err_cyc_q.size() == 1)
                chk({tag, "_err_latency"}, 128'(err_cyc_q[0]), 128'(tc));
        end
        chk({tag, "_wr_cnt"}, 128'(o_wr_cnt), 128'(m_wr_cnt));
        chk({tag, "_err_cnt"}, 128'(o_err_cnt), 128'(m_err_cnt));
        chk({tag, "_rule_held"}, 128'(o_type_rule), 128'(m_rule));
    endtask

    task automatic build_t1();
        cmd_start();
        add(32'h01020500, 1'b0);
        add(32'h11111111, 1'b0);
        add(32'h22222222, 1'b0);
        add(32'h0000003F, 1'b1);
    endtask

    task automatic build_random();
        int r, n, st, ix;
        r  = $urandom_range(0, 5);
        st = $urandom_range(0, STAGE_NUM - 1);
        ix = $urandom_range(0, RULE_NUM - 1);
        cmd_start();
        case (r)
            0, 2, 3: begin
                n = (r == 0) ? PW : (r == 2) ? $urandom_range(1, 2) : $urandom_range(4, 5);
                add(hdr(1, st, ix), 1'b0);
                for (int k = 1; k <= n; k++) add($urandom, 1'(k == n));
            end
            1: add(hdr(2, st, $urandom_range(0, 255)), 1'b1);
            4: begin
                add(hdr($urandom_range(3, 255), $urandom_range(0, 255), $urandom_range(0, 255)),
                    1'($urandom));
                if (!cl[0]) begin
                    n = $urandom_range(1, 3);
                    for (int k = 1; k <= n; k++) add($urandom, 1'(k == n));
                end
            end
            default: begin
                if ($urandom_range(0, 1) == 1) begin
                    add(hdr(2, $urandom_range(STAGE_NUM, 255), ix), 1'b1);
                end else begin
                    add(hdr(2, st, ix), 1'b0);
                    add($urandom, 1'b1);
                end
            end
        endcase
    endtask

    initial begin
        i_rst = 1'b1; i_cfg_valid = 1'b0; i_cfg_data = '0; i_cfg_last = 1'b0;
        m_wr_cnt = '0; m_err_cnt = '0; m_rule = '0;
        repeat (3) tick();
        chk("reset_ready", 128'(o_cfg_ready), 128'(0));
        chk("reset_wren", 128'(o_rule_wren), 128'(0));
        chk("reset_rule", 128'(o_type_rule), 128'(0));
        chk("reset_err", 128'(o_err), 128'(0));
        chk("reset_cnts", 128'({o_wr_cnt, o_err_cnt}), 128'(0));
        i_rst = 1'b0;
        tick();

        // T1 nominal write; check the literal rule and enable too
        build_t1();
        run_cmd("t1", 1'b0);
        chk("t1_literal_rule", 128'(o_type_rule), 128'(70'h3F_22222222_11111111));

        // T2 clear stage 1
        cmd_start();
        add(32'h02010000, 1'b1);
        run_cmd("t2", 1'b0);
        chk("t2_literal_rule", 128'(o_type_rule), 128'(0));

        // T3 short write then a valid write
        cmd_start();
        add(32'h01030700, 1'b0);
        add(32'hAAAA5555, 1'b0);
        add(32'h12345678, 1'b1);
        run_cmd("t3_short", 1'b0);
        build_t1();
        run_cmd("t3_after", 1'b0);

        // T4 long write drained
        cmd_start();
        add(32'h01000000, 1'b0);
        for (int k = 1; k <= 4; k++) add($urandom, 1'(k == 4));
        run_cmd("t4_long", 1'b0);

        // T5 bad opcode / stage / index without last
        cmd_start(); add(32'h07000000, 1'b0); add($urandom, 1'b0); add($urandom, 1'b1);
        run_cmd("t5_op", 1'b0);
        cmd_start(); add(32'h01040000, 1'b0); add($urandom, 1'b1);
        run_cmd("t5_stage", 1'b0);
        cmd_start(); add(32'h01000800, 1'b0); add($urandom, 1'b1);
        run_cmd("t5_idx", 1'b0);

        // T6 reset in the middle of a write
        ev_wren_q.delete();
        cmd_start();
        add(32'h01030200, 1'b0); add($urandom, 1'b0); add($urandom, 1'b0);
        exp_trig = 99;
        begin
            int unsigned dummy;
            drive(1'b0, dummy);
        end
        i_rst = 1'b1;
        #2;
        chk("t6_rst_ready", 128'(o_cfg_ready), 128'(0));
        chk("t6_rst_outs", 128'({o_rule_wren, o_type_rule, o_err}), 128'(0));
        chk("t6_rst_cnts", 128'({o_wr_cnt, o_err_cnt}), 128'(0));
        repeat (2) tick();
        i_rst = 1'b0;
        m_wr_cnt = '0; m_err_cnt = '0; m_rule = '0;
        repeat (5) tick();
        chk("t6_no_wren", 128'(ev_wren_q.size()), 128'(0));
        build_t1();
        run_cmd("t6_gapped_t1", 1'b1);

        // Counter saturation
        force dut.wr_cnt_q = 16'hFFFE;
        force dut.err_cnt_q = 16'hFFFE;
        #2;
        release dut.wr_cnt_q;
        release dut.err_cnt_q;
        m_wr_cnt = 16'hFFFE; m_err_cnt = 16'hFFFE;
        for (int i = 0; i < 2; i++) begin
            build_t1();
            run_cmd("sat_wr", 1'b0);
            cmd_start(); add(32'h09000000, 1'b1);
            run_cmd("sat_err", 1'b0);
        end

        // Randomized command stream with bubbles
        for (int i = 0; i < 60; i++) begin
            build_random();
            run_cmd("rand", 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
